// File: rtl/booth_mul_seq.sv
// -----------------------------------------------------------------------------
// booth_mul_seq
//
// Iterative radix-4 Booth multiplier. One operand pair is accepted in IDLE,
// the multiplier is recoded into Booth digits (neg/two/one per digit), and
// DIGITS_PER_CYCLE partial products are accumulated per BUSY cycle. The first
// DONE cycle registers the product and raises out_valid, which is then held
// until out_ready takes it.
//
// Parameters
//   bit_width         operand width (even, >= 4)
//   DIGITS_PER_CYCLE  Booth digits retired per BUSY cycle
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (aborts any operation)
//   in_valid   operand pair valid
//   in_ready   operand pair can be accepted (only in IDLE)
//   a          multiplicand
//   b          multiplier (Booth-recoded)
//   tc         1 = two's complement, 0 = unsigned (BOOTH_UNSIGNED_EN only)
//   out_valid  product valid, held until out_ready
//   out_ready  downstream accepts the product
//   product    full-width product a*b
//   busy       high whenever the block is not IDLE
//
// Configuration
//   BOOTH_UNSIGNED_EN  when defined, adds the tc port and unsigned mode
//                      (operands zero-extended, one extra Booth digit).
//                      When undefined the block is signed only.
// -----------------------------------------------------------------------------
module booth_mul_seq #(
    parameter int bit_width        = 16,
    parameter int DIGITS_PER_CYCLE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [bit_width-1:0]     a,
    input  logic [bit_width-1:0]     b,
`ifdef BOOTH_UNSIGNED_EN
    input  logic                     tc,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*bit_width-1:0]   product,
    output logic                     busy
);

    // Two guard bits keep -2 * min_int representable in the accumulator.
    localparam int ACC_W    = 2*bit_width + 2;
    // Multiplier register: two extension bits, the operand, and b[-1] = 0.
    localparam int MQ_W     = bit_width + 3;
    localparam int NDIG_MAX = bit_width/2 + 1;
    localparam int CNT_W    = $clog2(NDIG_MAX + DIGITS_PER_CYCLE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W-1:0]  a_sh;      // multiplicand, pre-shifted to the current digit group
    logic        [MQ_W-1:0]   mq;        // multiplier window, shifted right as digits retire
    logic        [CNT_W-1:0]  count;     // index of the first digit of the current group
    logic        [CNT_W-1:0]  ndig;      // number of Booth digits for this operation

    logic                     sgn_in;
    logic signed [ACC_W-1:0]  a_in_ext;
    logic        [MQ_W-1:0]   b_in_mq;
    logic        [CNT_W-1:0]  ndig_in;
    logic                     accept;
    logic                     last;

`ifdef BOOTH_UNSIGNED_EN
    assign sgn_in = tc;
`else
    assign sgn_in = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Booth digit -> partial product. The triple {b[2k+1], b[2k], b[2k-1]}
    // decodes to neg (top bit), one (|d| = 1) and two (|d| = 2).
    // -------------------------------------------------------------------------
    function automatic logic signed [ACC_W-1:0] booth_pp(
        input logic [2:0]              trip,
        input logic signed [ACC_W-1:0] m
    );
        logic                    neg;
        logic                    one;
        logic                    two;
        logic signed [ACC_W-1:0] mag;
        neg = trip[2];
        one = trip[1] ^ trip[0];
        two = (trip == 3'b011) || (trip == 3'b100);
        if (two)
            mag = m <<< 1;
        else if (one)
            mag = m;
        else
            mag = '0;
        return neg ? -mag : mag;
    endfunction

    // Operand extension at accept: signed mode sign-extends, unsigned mode
    // zero-extends, which also makes the extra top digit {0,0,b[msb]}.
    always_comb begin
        if (sgn_in) begin
            a_in_ext = {{(ACC_W-bit_width){a[bit_width-1]}}, a};
            b_in_mq  = {{2{b[bit_width-1]}}, b, 1'b0};
            ndig_in  = CNT_W'(bit_width/2);
        end else begin
            a_in_ext = {{(ACC_W-bit_width){1'b0}}, a};
            b_in_mq  = {2'b00, b, 1'b0};
            ndig_in  = CNT_W'(bit_width/2 + 1);
        end
    end

    assign accept   = in_valid && (state == IDLE);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign last     = (int'(count) + DIGITS_PER_CYCLE) >= int'(ndig);

    // Sum of this cycle's partial products; digits beyond ndig contribute 0.
    always_comb begin
        acc_nxt = acc;
        for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
            if ((int'(count) + j) < int'(ndig))
                acc_nxt = acc_nxt + booth_pp(mq[2*j+2 -: 3], a_sh <<< (2*j));
        end
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)                  state_nxt = BUSY;
            BUSY:    if (last)                    state_nxt = DONE;
            DONE:    if (out_valid && out_ready)  state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: operand capture, accumulation, product register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            a_sh      <= '0;
            mq        <= '0;
            count     <= '0;
            ndig      <= '0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= '0;
                        a_sh  <= a_in_ext;
                        mq    <= b_in_mq;
                        count <= '0;
                        ndig  <= ndig_in;
                    end
                end
                BUSY: begin
                    acc   <= acc_nxt;
                    a_sh  <= a_sh <<< (2*DIGITS_PER_CYCLE);
                    // Fill with the extension bit so digits past the operand stay 0.
                    mq    <= {{(2*DIGITS_PER_CYCLE){mq[MQ_W-1]}},
                              mq[MQ_W-1:2*DIGITS_PER_CYCLE]};
                    count <= count + CNT_W'(DIGITS_PER_CYCLE);
                end
                DONE: begin
                    // First DONE cycle publishes the product; it then stays
                    // stable until the handshake.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        product   <= acc[2*bit_width-1:0];
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mul_seq
//
// Directed and random checks of booth_mul_seq. dut1 retires one digit per
// cycle, dut2 retires two. Unsigned-mode vectors run only when
// BOOTH_UNSIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv1, iv2;
    logic        ir1, ir2;
    logic        ov1, ov2;
    logic        bz1, bz2;
    logic        out_ready;
    logic        tc;
    logic [15:0] a, b;
    logic [31:0] p1, p2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    booth_mul_seq #(.bit_width(16), .DIGITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
`ifdef BOOTH_UNSIGNED_EN
        .tc(tc),
`endif
        .out_valid(ov1), .out_ready(out_ready), .product(p1), .busy(bz1)
    );

    booth_mul_seq #(.bit_width(16), .DIGITS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a), .b(b),
`ifdef BOOTH_UNSIGNED_EN
        .tc(tc),
`endif
        .out_valid(ov2), .out_ready(out_ready), .product(p2), .busy(bz2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                            input logic tcv);
        longint sx, sy;
        if (tcv) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'(x);
            sy = longint'(y);
        end
        return 32'(sx * sy);
    endfunction

    // Present a pair to the selected DUT (which must be IDLE) and let the
    // accept edge pass; the operands are then scrambled.
    task automatic start_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                            input logic tcv);
        a = av; b = bv; tc = tcv; out_ready = 1'b0;
        if (sel == 1) iv1 = 1'b1; else iv2 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0; iv2 = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
    endtask

    // Number of edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(input int sel, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!((sel == 1) ? ov1 : ov2) && lat < 64);
    endtask

    task automatic take(input int sel, input int stall, output logic [31:0] p);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        p = (sel == 1) ? p1 : p2;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                          input logic tcv, input int stall, input logic [31:0] exp,
                          input int exp_lat, input string tag);
        int          lat;
        logic [31:0] p;
        start_op(sel, av, bv, tcv);
        wait_valid(sel, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        take(sel, stall, p);
        chk({tag, "_prod"}, 64'(p), 64'(exp));
    endtask

    initial begin
        int          lat;
        logic [15:0] ra, rb;
        logic        rt;
        int          el;

        rst = 1'b1; iv1 = 1'b0; iv2 = 1'b0; out_ready = 1'b0;
        tc = 1'b1; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ov1), 64'd0);
        chk("rst_product",   64'(p1),  64'd0);
        chk("rst_busy",      64'(bz1), 64'd0);
        chk("rst_in_ready",  64'(ir1), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic signed vectors and the min_int corners
        run_op(1, 16'hFFFD, 16'h0007, 1'b1, 0, 32'hFFFFFFEB, 9, "neg3x7");
        run_op(1, 16'h8000, 16'h8000, 1'b1, 0, 32'h40000000, 9, "min_min");
        run_op(1, 16'h7FFF, 16'h8000, 1'b1, 2, 32'hC0008000, 9, "max_min");
        run_op(1, 16'h0000, 16'h1234, 1'b1, 0, 32'h00000000, 9, "zero");
        run_op(1, 16'h0001, 16'hFFFF, 1'b1, 1, 32'hFFFFFFFF, 9, "one_neg1");
        run_op(1, 16'h7FFF, 16'h7FFF, 1'b1, 0, 32'h3FFF0001, 9, "max_max");

        // Hold DONE with out_ready low while inputs wiggle
        start_op(1, 16'h0011, 16'h0101, 1'b1);
        wait_valid(1, lat);
        chk("stall_lat", 64'(lat), 64'd9);
        for (int i = 0; i < 5; i++) begin
            iv1 = (i % 2 == 0);
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            chk("stall_prod",     64'(p1),  64'h1111);
            chk("stall_in_ready", 64'(ir1), 64'd0);
            chk("stall_valid",    64'(ov1), 64'd1);
        end
        iv1 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hs_valid_low", 64'(ov1), 64'd0);
        chk("hs_in_ready",  64'(ir1), 64'd1);
        @(posedge clk); #1;
        chk("hs_one_only", 64'(ov1), 64'd0);
        chk("hs_idle",     64'(bz1), 64'd0);

        // Abort with reset on the third BUSY cycle
        start_op(1, 16'h1234, 16'h5678, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_abort_busy", 64'(bz1), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_valid",    64'(ov1), 64'd0);
        chk("abort_product",  64'(p1),  64'd0);
        chk("abort_in_ready", 64'(ir1), 64'd1);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_valid", 64'(ov1), 64'd0);
        run_op(1, 16'h0003, 16'h0005, 1'b1, 0, 32'h0000000F, 9, "after_abort");

        // Two digits per cycle
        run_op(2, 16'h1234, 16'hFEDC, 1'b1, 0, 32'hFFEB3CB0, 5, "dpc2");
        run_op(2, 16'h8000, 16'h8000, 1'b1, 1, 32'h40000000, 5, "dpc2_min");

`ifdef BOOTH_UNSIGNED_EN
        run_op(1, 16'hFFFF, 16'hFFFF, 1'b0, 0, 32'hFFFE0001, 10, "uns_ff");
        run_op(1, 16'hFFFF, 16'hFFFF, 1'b1, 0, 32'h00000001, 9,  "sgn_ff");
        run_op(2, 16'hFFFF, 16'hFFFF, 1'b0, 0, 32'hFFFE0001, 6,  "uns_ff_dpc2");
        run_op(1, 16'h8000, 16'h8000, 1'b0, 0, 32'h40000000, 10, "uns_min");
`endif

        // Random pairs with random output stalls
        for (int i = 0; i < 2500; i++) begin
            int sel;
            sel = (i % 5 == 4) ? 2 : 1;
            ra = 16'($urandom);
            rb = 16'($urandom);
`ifdef BOOTH_UNSIGNED_EN
            rt = 1'($urandom);
`else
            rt = 1'b1;
`endif
            if (sel == 1) el = rt ? 9 : 10;
            else          el = rt ? 5 : 6;
            run_op(sel, ra, rb, rt, int'($urandom_range(0, 3)),
                   ref_mul(ra, rb, rt), el, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
